// File: rtl/spi_rx_mem_loader.sv
// spi_rx_mem_loader: SPI mode-0 slave that unpacks framed byte streams into act/param/inst memory writes.
// Define SPI_RX_STATUS_EN to add the rx_byte_count and rx_xor frame status outputs.
module spi_rx_mem_loader #(
  parameter int WIDTH_SPI_WORD = 8,
  parameter int WIDTH_ADDR_ACT = 12,
  parameter int WIDTH_ACT_MEM = 8,
  parameter int DEPTH_ACT_MEM = 4096,
  parameter logic [1:0] ACT_MEM_HEADER = 2'b10,
  parameter int WIDTH_ADDR_PARAM = 13,
  parameter int WIDTH_PARAM_MEM = 128,
  parameter int DEPTH_PARAM_MEM = 7000,
  parameter logic [1:0] PARAM_MEM_HEADER = 2'b01,
  parameter int WIDTH_ADDR_INST = 6,
  parameter int WIDTH_INST_MEM = 80,
  parameter int DEPTH_INST_MEM = 64,
  parameter logic [1:0] INST_MEM_HEADER = 2'b11
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        spi_clk,
  input  logic                        MOSI,
  input  logic                        chip_select_n,
  output logic                        act_wr_en,
  output logic [WIDTH_ADDR_ACT-1:0]   act_addr,
  output logic [WIDTH_ACT_MEM-1:0]    act_wr_data,
  output logic                        param_wr_en,
  output logic [WIDTH_ADDR_PARAM-1:0] param_addr,
  output logic [WIDTH_PARAM_MEM-1:0]  param_wr_data,
  output logic                        inst_wr_en,
  output logic [WIDTH_ADDR_INST-1:0]  inst_addr,
  output logic [WIDTH_INST_MEM-1:0]   inst_wr_data,
  output logic                        busy,
  output logic                        frame_err
`ifdef SPI_RX_STATUS_EN
  ,
  output logic [15:0]                 rx_byte_count,
  output logic [7:0]                  rx_xor
`endif
);
  localparam int SW = WIDTH_SPI_WORD;
  localparam int AW = 2 * SW;
  localparam int BW = $clog2(SW);
  localparam int WPI = WIDTH_PARAM_MEM > WIDTH_INST_MEM ? WIDTH_PARAM_MEM : WIDTH_INST_MEM;
  localparam int WW = WPI > WIDTH_ACT_MEM ? WPI : WIDTH_ACT_MEM;
  localparam int BPW_ACT = WIDTH_ACT_MEM / SW;
  localparam int BPW_PARAM = WIDTH_PARAM_MEM / SW;
  localparam int BPW_INST = WIDTH_INST_MEM / SW;
  typedef enum logic [2:0] {IDLE, HDR, ADDR_HI, ADDR_LO, PAYLOAD, DISCARD} state_t;
  state_t state, nxt;
  logic [1:0] sclk_s, mosi_s, cs_s;
  logic sclk_q, cs_q, byte_valid;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] shreg, addr_hi;
  logic [7:0] byte_cnt;
  logic [1:0] tgt;
  logic [AW-1:0] addr, addr_raw, addr_ld;
  logic [WW-SW-1:0] word;
  logic [WW-1:0] word_nx;
  logic rise, cs_fall, cs_rise, hdr_ok, last, in_range, pay, strobe, wr, set_err;
  assign busy = state != IDLE;
  always_comb begin
    rise = sclk_s[1] & ~sclk_q;
    cs_fall = cs_q & ~cs_s[1];
    cs_rise = ~cs_q & cs_s[1];
    hdr_ok = shreg[SW-1 -: 2] inside {ACT_MEM_HEADER, PARAM_MEM_HEADER, INST_MEM_HEADER};
    last = tgt == ACT_MEM_HEADER ? byte_cnt == 8'(BPW_ACT - 1) :
           tgt == PARAM_MEM_HEADER ? byte_cnt == 8'(BPW_PARAM - 1) : byte_cnt == 8'(BPW_INST - 1);
    in_range = tgt == ACT_MEM_HEADER ? 32'(addr) < DEPTH_ACT_MEM :
               tgt == PARAM_MEM_HEADER ? 32'(addr) < DEPTH_PARAM_MEM : 32'(addr) < DEPTH_INST_MEM;
    addr_raw = {addr_hi, shreg};
    addr_ld = tgt == ACT_MEM_HEADER ? AW'(addr_raw[WIDTH_ADDR_ACT-1:0]) :
              tgt == PARAM_MEM_HEADER ? AW'(addr_raw[WIDTH_ADDR_PARAM-1:0]) : AW'(addr_raw[WIDTH_ADDR_INST-1:0]);
    word_nx = {word, shreg};
    pay = state == PAYLOAD && byte_valid;
    strobe = pay && last;
    wr = strobe && in_range;
    // a word is only partial when some of its bytes have already been accepted
    set_err = (state == HDR && byte_valid && !hdr_ok) || (strobe && !in_range) ||
              (cs_rise && state == PAYLOAD && byte_cnt != 8'd0 && !strobe);
    nxt = state;
    if (cs_rise) nxt = IDLE;
    else if (cs_fall) nxt = HDR;
    else if (byte_valid)
      case (state)
        HDR:     nxt = hdr_ok ? ADDR_HI : DISCARD;
        ADDR_HI: nxt = ADDR_LO;
        ADDR_LO: nxt = PAYLOAD;
        PAYLOAD: nxt = strobe && !in_range ? DISCARD : PAYLOAD;
        default: nxt = state;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_s <= '0;
      mosi_s <= '0;
      cs_s <= '0;
      sclk_q <= 1'b0;
      cs_q <= 1'b0;
      byte_valid <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      addr_hi <= '0;
      byte_cnt <= '0;
      tgt <= '0;
      addr <= '0;
      word <= '0;
      frame_err <= 1'b0;
      act_wr_en <= 1'b0;
      act_addr <= '0;
      act_wr_data <= '0;
      param_wr_en <= 1'b0;
      param_addr <= '0;
      param_wr_data <= '0;
      inst_wr_en <= 1'b0;
      inst_addr <= '0;
      inst_wr_data <= '0;
    end else begin
      sclk_s <= {sclk_s[0], spi_clk};
      mosi_s <= {mosi_s[0], MOSI};
      cs_s <= {cs_s[0], chip_select_n};
      sclk_q <= sclk_s[1];
      cs_q <= cs_s[1];
      byte_valid <= 1'b0;
      if (cs_fall || cs_rise) bit_cnt <= '0;
      else if (rise && !cs_s[1] && state != IDLE) begin
        shreg <= {shreg[SW-2:0], mosi_s[1]};
        bit_cnt <= bit_cnt == BW'(SW - 1) ? '0 : bit_cnt + BW'(1);
        byte_valid <= bit_cnt == BW'(SW - 1);
      end
      if (cs_fall) byte_cnt <= '0;
      else if (pay) byte_cnt <= last ? '0 : byte_cnt + 8'd1;
      if (state == HDR && byte_valid) tgt <= shreg[SW-1 -: 2];
      if (state == ADDR_HI && byte_valid) addr_hi <= shreg;
      if (state == ADDR_LO && byte_valid) addr <= addr_ld;
      else if (wr) addr <= addr + AW'(1);
      if (pay) word <= word_nx[WW-SW-1:0];
      if (cs_fall) frame_err <= 1'b0;
      else if (set_err) frame_err <= 1'b1;
      act_wr_en <= wr && tgt == ACT_MEM_HEADER;
      param_wr_en <= wr && tgt == PARAM_MEM_HEADER;
      inst_wr_en <= wr && tgt == INST_MEM_HEADER;
      if (wr && tgt == ACT_MEM_HEADER) begin
        act_addr <= addr[WIDTH_ADDR_ACT-1:0];
        act_wr_data <= word_nx[WIDTH_ACT_MEM-1:0];
      end
      if (wr && tgt == PARAM_MEM_HEADER) begin
        param_addr <= addr[WIDTH_ADDR_PARAM-1:0];
        param_wr_data <= word_nx[WIDTH_PARAM_MEM-1:0];
      end
      if (wr && tgt == INST_MEM_HEADER) begin
        inst_addr <= addr[WIDTH_ADDR_INST-1:0];
        inst_wr_data <= word_nx[WIDTH_INST_MEM-1:0];
      end
    end
`ifdef SPI_RX_STATUS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_byte_count <= '0;
      rx_xor <= '0;
    end else if (cs_fall) begin
      rx_byte_count <= '0;
      rx_xor <= '0;
    end else if (byte_valid) begin
      rx_byte_count <= rx_byte_count + 16'd1;
      if (state == PAYLOAD) rx_xor <= rx_xor ^ shreg[7:0];
    end
`endif
endmodule

// File: tb/tb_spi_rx_mem_loader.sv
// tb_spi_rx_mem_loader: scoreboard bench driving SPI frames against a frame-level write model.
module tb_spi_rx_mem_loader;
  logic clk = 1'b0, reset_n = 1'b0, spi_clk = 1'b0, MOSI = 1'b0, chip_select_n = 1'b1;
  logic act_wr_en, param_wr_en, inst_wr_en, busy, frame_err;
  logic [11:0] act_addr;
  logic [7:0] act_wr_data;
  logic [12:0] param_addr;
  logic [127:0] param_wr_data;
  logic [5:0] inst_addr;
  logic [79:0] inst_wr_data;
`ifdef SPI_RX_STATUS_EN
  logic [15:0] rx_byte_count;
  logic [7:0] rx_xor;
`endif
  typedef struct packed {logic [1:0] tgt; logic [15:0] addr; logic [127:0] data;} wr_t;
  wr_t exp_q[$];
  bit exp_err;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  spi_rx_mem_loader dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .MOSI(MOSI), .chip_select_n(chip_select_n),
    .act_wr_en(act_wr_en), .act_addr(act_addr), .act_wr_data(act_wr_data),
    .param_wr_en(param_wr_en), .param_addr(param_addr), .param_wr_data(param_wr_data),
    .inst_wr_en(inst_wr_en), .inst_addr(inst_addr), .inst_wr_data(inst_wr_data),
    .busy(busy), .frame_err(frame_err)
`ifdef SPI_RX_STATUS_EN
    , .rx_byte_count(rx_byte_count), .rx_xor(rx_xor)
`endif
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  function automatic int bpw_of(input logic [1:0] t);
    return t == 2'b10 ? 1 : t == 2'b01 ? 16 : 10;
  endfunction
  function automatic int aw_of(input logic [1:0] t);
    return t == 2'b10 ? 12 : t == 2'b01 ? 13 : 6;
  endfunction
  function automatic int depth_of(input logic [1:0] t);
    return t == 2'b10 ? 4096 : t == 2'b01 ? 7000 : 64;
  endfunction

  // Frame-level model: whole words land at successive addresses until one falls off the memory.
  function automatic void model(input logic [7:0] fr[$]);
    int n, a, p, bpw;
    logic [1:0] t;
    logic [127:0] d;
    n = fr.size();
    exp_err = 1'b0;
    if (n == 0) return;
    t = fr[0][7:6];
    if (t == 2'b00) begin
      exp_err = 1'b1;
      return;
    end
    if (n < 3) return;
    bpw = bpw_of(t);
    a = ((int'(fr[1]) << 8) | int'(fr[2])) % (1 << aw_of(t));
    p = 3;
    while (p + bpw <= n) begin
      if (a >= depth_of(t)) begin
        exp_err = 1'b1;
        return;
      end
      d = '0;
      for (int k = 0; k < bpw; k++) d = (d << 8) | 128'(fr[p + k]);
      exp_q.push_back('{t, 16'(a), d});
      a++;
      p += bpw;
    end
    if (p < n) exp_err = 1'b1;
  endfunction

  task automatic send_bit(input logic b);
    MOSI = b;
    #40 spi_clk = 1'b1;
    #40 spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input int extra_bits);
    model(fr);
    chip_select_n = 1'b0;
    #80;
    check("busy_on", busy, 1);
    check("err_cleared_on_cs_fall", frame_err, 0);
    foreach (fr[i]) send_byte(fr[i]);
    for (int i = 0; i < extra_bits; i++) send_bit(1'($urandom));
    #80 chip_select_n = 1'b1;
    #100;
    check("busy_off", busy, 0);
    check("frame_err", frame_err, exp_err);
    check("missing_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk)
    if (act_wr_en || param_wr_en || inst_wr_en) begin
      wr_t e, g;
      check("wr_onehot", $countones({act_wr_en, param_wr_en, inst_wr_en}), 1);
      g.tgt = act_wr_en ? 2'b10 : param_wr_en ? 2'b01 : 2'b11;
      g.addr = act_wr_en ? 16'(act_addr) : param_wr_en ? 16'(param_addr) : 16'(inst_addr);
      g.data = act_wr_en ? 128'(act_wr_data) : param_wr_en ? param_wr_data : 128'(inst_wr_data);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: tgt %0h addr %0h data %0h, want no write", g.tgt, g.addr, g.data);
      end else begin
        e = exp_q.pop_front();
        check("wr_target", g.tgt, e.tgt);
        check("wr_addr", g.addr, e.addr);
        check("wr_data", g.data, e.data);
      end
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[$];
    logic [1:0] t;
    logic [15:0] a;
    int k, len;
    #20;
    check("rst_wr_en", {act_wr_en, param_wr_en, inst_wr_en}, 0);
    check("rst_busy_err", {busy, frame_err}, 0);
    #20 reset_n = 1'b1;
    #40;
    fr = {8'h80, 8'h00, 8'h05, 8'hAA, 8'h55};
    run_frame(fr, 0);
    check("act_addr_hold", act_addr, 12'h006);
    check("act_data_hold", act_wr_data, 8'h55);
`ifdef SPI_RX_STATUS_EN
    check("rx_byte_count", rx_byte_count, 5);
    check("rx_xor", rx_xor, 8'hFF);
`endif
    fr = {8'h40, 8'h00, 8'h02};
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    run_frame(fr, 0);
    fr = {8'hC0, 8'h00, 8'h00};
    for (int i = 0; i < 20; i++) fr.push_back(8'($urandom));
    run_frame(fr, 0);
    fr = {8'h00, 8'h12, 8'h34, 8'h56};
    run_frame(fr, 0);
    fr = {8'h40, 8'h00, 8'h03};
    for (int i = 0; i < 7; i++) fr.push_back(8'($urandom));
    run_frame(fr, 3);
    fr = {8'h80, 8'h00, 8'h05};
    run_frame(fr, 0);
    fr = {8'h40};
    run_frame(fr, 5);
    fr = {8'h80, 8'h0F, 8'hFF, 8'hA1, 8'hB2};
    run_frame(fr, 0);
    fr = {8'hC0, 8'h00, 8'h3F};
    for (int i = 0; i < 20; i++) fr.push_back(8'($urandom));
    run_frame(fr, 0);
    // asynchronous reset in the middle of a byte, then the rest of that frame must be ignored
    fr = {8'h80, 8'h00, 8'h10, 8'h11, 8'h22};
    model(fr);
    chip_select_n = 1'b0;
    #80;
    foreach (fr[i]) send_byte(fr[i]);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #20;
    check("pre_reset_addr", act_addr, 12'h011);
    reset_n = 1'b0;
    #1;
    check("mid_rst_act", {act_wr_en, act_addr, act_wr_data}, 0);
    check("mid_rst_busy_err", {busy, frame_err, param_wr_en, inst_wr_en}, 0);
    #29 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    #80 chip_select_n = 1'b1;
    #100;
    check("post_rst_busy", busy, 0);
    check("post_rst_pending", exp_q.size(), 0);
    exp_q.delete();
    fr = {8'h80, 8'h01, 8'h00, 8'h5A, 8'hC3};
    run_frame(fr, 0);
    for (int f = 0; f < 14; f++) begin
      k = $urandom_range(0, 7);
      t = k == 0 ? 2'b00 : k < 3 ? 2'b10 : k < 5 ? 2'b01 : 2'b11;
      a = 16'($urandom);
      if (t != 2'b00 && $urandom_range(0, 1) == 1)
        a = 16'(depth_of(t) - int'($urandom_range(1, 3))) | (a & ~16'((1 << aw_of(t)) - 1));
      len = t == 2'b00 ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2 * bpw_of(t) + 3));
      fr = {{t, 6'($urandom)}};
      if ($urandom_range(0, 7) != 0) begin
        fr.push_back(a[15:8]);
        fr.push_back(a[7:0]);
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      end
      run_frame(fr, int'($urandom_range(0, 7)));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
